// File: rtl/median_pkg.sv
// Shared types and default constants for the median engine arbiter.
package median_pkg;

  localparam int unsigned DefSize = 8;
  localparam int unsigned DefWin  = 9;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StFeed,
    StWait,
    StResult
  } state_t;

endpackage

// File: rtl/median_arbiter_if.sv
// Requester, engine and result signals of the median arbiter, grouped as one bundle.
interface median_arbiter_if #(
  parameter int unsigned SIZE  = median_pkg::DefSize,
  parameter int unsigned N_REQ = 4
);

  localparam int unsigned IdW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*SIZE-1:0] req_data;
  logic [SIZE-1:0]       eng_di;
  logic                  eng_dsi;
  logic [SIZE-1:0]       eng_do;
  logic                  eng_dso;
  logic                  res_valid;
  logic                  res_ready;
  logic [SIZE-1:0]       res_data;
  logic [IdW-1:0]        res_id;
  logic                  res_err;
  logic                  busy;

  modport slave (
    input  req_valid, req_data, eng_do, eng_dso, res_ready,
    output req_ready, eng_di, eng_dsi, res_valid, res_data, res_id, res_err, busy
  );

  modport master (
    output req_valid, req_data, eng_do, eng_dso, res_ready,
    input  req_ready, eng_di, eng_dsi, res_valid, res_data, res_id, res_err, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IdW   = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdW-1:0]   ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IdW-1:0]   idx_o
);

  always_comb begin
    logic        found;
    int unsigned j;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = (32'(ptr_i) + i) % N_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IdW'(j);
      end
    end
  end

endmodule

// File: rtl/median_arbiter.sv
// Round-robin front end sharing one median engine: collect a window, feed it, await DSO,
// and return the tagged median (or a timeout error) on the result port.
module median_arbiter
  import median_pkg::*;
#(
  parameter int unsigned SIZE    = DefSize,
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIN     = DefWin,
  parameter int unsigned TIMEOUT = 64
) (
  input logic             CLK,
  input logic             nRST,
  median_arbiter_if.slave bus
);

  localparam int unsigned IdW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = $clog2(WIN + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [IdW-1:0]  grant_q, grant_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [SIZE-1:0] res_data_q, res_data_d;
  logic            res_err_q, res_err_d;
  logic [SIZE-1:0] buf_q [WIN];
  logic            buf_we;
  logic [SIZE-1:0] req_sel;

  logic [N_REQ-1:0] arb_gnt;
  logic [IdW-1:0]   arb_idx;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IdW   (IdW)
  ) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign req_sel = bus.req_data[int'(grant_q)*SIZE +: SIZE];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    buf_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|arb_gnt) begin
          grant_d = arb_idx;
          cnt_d   = '0;
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (bus.req_valid[grant_q]) begin
          buf_we = 1'b1;
          if (cnt_q == CntW'(WIN - 1)) begin
            cnt_d   = '0;
            state_d = StFeed;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StFeed: begin
        if (cnt_q == CntW'(WIN - 1)) begin
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWait: begin
        tmo_d = tmo_q + TmoW'(1);
        // First WAIT cycle may still see the previous job's DSO, so skip it.
        if (tmo_q != '0 && bus.eng_dso) begin
          res_data_d = bus.eng_do;
          res_err_d  = 1'b0;
          state_d    = StResult;
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = StResult;
        end
      end
      StResult: begin
        if (bus.res_ready) begin
          ptr_d   = (grant_q == IdW'(N_REQ - 1)) ? '0 : grant_q + IdW'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      for (int unsigned i = 0; i < WIN; i++) buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      if (buf_we) buf_q[cnt_q] <= req_sel;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == StCollect) bus.req_ready[grant_q] = 1'b1;
  end

  assign bus.eng_dsi   = (state_q == StFeed);
  assign bus.eng_di    = (state_q == StFeed) ? buf_q[cnt_q] : '0;
  assign bus.res_valid = (state_q == StResult);
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = grant_q;
  assign bus.res_err   = res_err_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_median_arbiter.sv
// Directed bench for median_arbiter with a behavioural 9-sample median engine attached.
module tb_median_arbiter;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  median_arbiter_if #(.SIZE(8), .N_REQ(4)) bus ();

  median_arbiter #(
    .SIZE    (8),
    .N_REQ   (4),
    .WIN     (9),
    .TIMEOUT (64)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Engine model: loads on DSI, clears DSO on load, raises DSO with the median once DSI drops.
  bit         eng_dead = 1'b0;
  int         eng_cnt  = 0;
  logic [7:0] ewin [9];
  logic [7:0] feed_log [256];
  int         feed_n   = 0;
  int         rises    = 0;
  logic       dsi_prev = 1'b0;

  function automatic logic [7:0] median9(input logic [7:0] a [9]);
    logic [7:0] s [9];
    logic [7:0] t;
    s = a;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    return s[4];
  endfunction

  always @(posedge CLK) begin
    if (!nRST) begin
      eng_cnt     <= 0;
      bus.eng_dso <= 1'b0;
      bus.eng_do  <= '0;
    end else if (bus.eng_dsi) begin
      if (eng_cnt < 9) ewin[eng_cnt] <= bus.eng_di;
      eng_cnt          <= eng_cnt + 1;
      bus.eng_dso      <= 1'b0;
      feed_log[feed_n] <= bus.eng_di;
      feed_n           <= feed_n + 1;
      if (!dsi_prev) rises <= rises + 1;
    end else if (eng_cnt == 9) begin
      bus.eng_do  <= median9(ewin);
      bus.eng_dso <= !eng_dead;
      eng_cnt     <= 0;
    end
    dsi_prev <= bus.eng_dsi;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_win(input int r, input logic [7:0] v [9], input bit gappy);
    for (int k = 0; k < 9; k++) begin
      int budget;
      budget = 0;
      bus.req_valid[r]       = 1'b1;
      bus.req_data[r*8 +: 8] = v[k];
      while (!bus.req_ready[r] && budget < 300) begin
        step(1);
        budget++;
      end
      if (budget >= 300) begin
        check("grant_wait", 32'd0, 32'd1);
        bus.req_valid[r] = 1'b0;
        return;
      end
      check("ready_onehot", 32'(bus.req_ready), 32'd1 << r);
      step(1);
      if (gappy) begin
        bus.req_valid[r] = 1'b0;
        step(1);
      end
    end
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic wait_result();
    int budget;
    budget = 0;
    while (!bus.res_valid && budget < 300) begin
      step(1);
      budget++;
    end
    if (budget >= 300) check("result_wait", 32'd0, 32'd1);
  endtask

  task automatic ack();
    bus.res_ready = 1'b1;
    step(1);
    bus.res_ready = 1'b0;
  endtask

  task automatic check_res(input string tag, input int data, input int id, input int err);
    check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.res_data), 32'(data));
    check({tag, "_id"}, 32'(bus.res_id), 32'(id));
    check({tag, "_err"}, 32'(bus.res_err), 32'(err));
  endtask

  task automatic check_feed(input int base_n, input int base_r, input logic [7:0] v [9]);
    check("feed_len", 32'(feed_n - base_n), 32'd9);
    check("dsi_runs", 32'(rises - base_r), 32'd1);
    for (int k = 0; k < 9; k++) check("feed_order", 32'(feed_log[base_n + k]), 32'(v[k]));
  endtask

  logic [7:0] w0 [9] = '{8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6};
  logic [7:0] w2 [9] = '{8'd10, 8'd90, 8'd30, 8'd70, 8'd50, 8'd20, 8'd80, 8'd40, 8'd60};
  logic [7:0] w3 [9] = '{8'd3, 8'd33, 8'd13, 8'd23, 8'd43, 8'd53, 8'd63, 8'd73, 8'd83};
  logic [7:0] w1 [9] = '{8'd9, 8'd7, 8'd5, 8'd3, 8'd1, 8'd2, 8'd4, 8'd6, 8'd8};

  initial begin
    int bn, br, n, bad;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;
    step(3);

    // Reset state
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_dsi", 32'(bus.eng_dsi), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    nRST = 1'b1;
    step(2);

    // 1: single job from req0
    bn = feed_n; br = rises;
    send_win(0, w0, 1'b0);
    wait_result();
    check_res("t1", 5, 0, 0);
    check_feed(bn, br, w0);
    ack();

    // 2: pointer back to 0, req0 and req2 together, then req1/req3 with pointer at 3
    nRST = 1'b0;
    step(1);
    nRST = 1'b1;
    bus.req_valid[2]    = 1'b1;
    bus.req_data[23:16] = 8'd40;
    send_win(0, w0, 1'b0);
    wait_result();
    check_res("t2a", 5, 0, 0);
    ack();
    bn = feed_n; br = rises;
    send_win(2, w2, 1'b0);
    wait_result();
    check_res("t2b", 50, 2, 0);
    check_feed(bn, br, w2);
    ack();
    bus.req_valid[1]  = 1'b1;
    bus.req_data[15:8] = 8'd0;
    send_win(3, w3, 1'b0);
    wait_result();
    check_res("t2c", 43, 3, 0);
    ack();
    bus.req_valid[1] = 1'b0;

    // 3: req1 with gaps in VALID
    bn = feed_n; br = rises;
    send_win(1, w1, 1'b1);
    wait_result();
    check_res("t3", 5, 1, 0);
    check_feed(bn, br, w1);

    // 4: consumer stalls 20 cycles while req0 waits
    bus.req_valid[0]  = 1'b1;
    bus.req_data[7:0] = w0[0];
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.res_valid !== 1'b1 || bus.res_data !== 8'd5 || bus.res_id !== 2'd1 ||
          bus.req_ready !== 4'b0000)
        bad++;
    end
    check("stall_stable", 32'(bad), 32'd0);
    ack();
    check("grant_after_ack_idle", 32'(bus.req_ready), 32'd0);
    step(1);
    check("grant_after_ack", 32'(bus.req_ready), 32'b0001);

    // 5: dead engine -> timeout error
    eng_dead = 1'b1;
    send_win(0, w0, 1'b0);
    n = 0;
    while (bus.eng_dsi && n < 50) begin
      step(1);
      n++;
    end
    n = 0;
    while (!bus.res_valid && n < 200) begin
      step(1);
      n++;
    end
    check("tmo_latency", 32'(n), 32'd64);
    check_res("t5", 0, 0, 1);
    ack();
    eng_dead = 1'b0;

    // 6: reset during FEED cycle 4 aborts the job
    send_win(0, w0, 1'b0);
    check("t6_feed0", 32'(bus.eng_dsi), 32'd1);
    step(4);
    nRST = 1'b0;
    step(1);
    check("t6_dsi", 32'(bus.eng_dsi), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_res_valid", 32'(bus.res_valid), 32'd0);
    nRST = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("t6_no_result", 32'(bad), 32'd0);
    bn = feed_n; br = rises;
    send_win(0, w0, 1'b0);
    wait_result();
    check_res("t6", 5, 0, 0);
    check_feed(bn, br, w0);
    ack();
    check("t6_idle", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
